// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl
//
// Multi-cycle sequencer that time-shares one external 4-bit full adder to add
// WORD_W-bit operands. It processes one SLICE_W-bit slice per cycle, LSB first.
// The carry between slices is held in a register.
//
// FSM: StIdle -> StRun -> StDone -> StIdle (2-bit encoding).
//   - StIdle: in_ready=1. An accept latches the operands and enters StRun.
//   - StRun: NSLICE cycles. Each cycle drives one slice to the adder and
//     captures the adder result at the next edge.
//   - StDone: res_valid=1 until res_ready is seen.
//
// Optional feature (macro ADDSEQ_SUB_EN):
//   - Adds input in_sub, which is latched at accept.
//   - With in_sub=1 the block computes A - B mod 2^WORD_W. B is inverted and the
//     initial carry is forced to 1. res_cout=1 then means "no borrow".
//   - Without the macro the block only adds.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   in_valid/in_ready    request handshake; accept when both high
//   in_a, in_b, in_cin   operands and carry-in, sampled only at accept
//   in_sub               (ADDSEQ_SUB_EN only) subtract select, sampled at accept
//   add_a/add_b/add_cin  slice operands to the shared adder; 0 outside StRun
//   add_s/add_cout       combinational slice sum / carry back from the adder
//   res_valid/res_ready  result handshake; consumed when both high
//   res_sum, res_cout    WORD_W-bit sum and carry out of the top slice
//   busy                 high in StRun or StDone

module adder_seq_ctrl #(
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned SLICE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_a,
  input  logic [WORD_W-1:0]  in_b,
  input  logic               in_cin,
`ifdef ADDSEQ_SUB_EN
  input  logic               in_sub,
`endif
  output logic [SLICE_W-1:0] add_a,
  output logic [SLICE_W-1:0] add_b,
  output logic               add_cin,
  input  logic [SLICE_W-1:0] add_s,
  input  logic               add_cout,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WORD_W-1:0]  res_sum,
  output logic               res_cout,
  output logic               busy
);

  localparam int unsigned NSLICE = WORD_W / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e state_q;

  // Latched operands, viewed as slices so the current slice is a plain index.
  logic [NSLICE-1:0][SLICE_W-1:0] a_q;
  logic [NSLICE-1:0][SLICE_W-1:0] b_q;
  logic [NSLICE-1:0][SLICE_W-1:0] sum_q;

  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_nxt;
  logic               carry_q;
  logic [SLICE_W-1:0] add_a_q;
  logic [SLICE_W-1:0] add_b_q;
  logic               in_ready_q;
  logic               res_valid_q;
  logic               res_cout_q;
  logic               busy_q;

  // Effective B and initial carry at accept time.
  // - Subtraction is folded in here, so the datapath in StRun is the same for
  //   add and subtract.
  // - Storing ~B is equivalent to inverting each slice on its way to add_b.
  logic [WORD_W-1:0] b_eff;
  logic              cin_eff;

  always_comb begin
    b_eff   = in_b;
    cin_eff = in_cin;
`ifdef ADDSEQ_SUB_EN
    if (in_sub) begin
      b_eff   = ~in_b;
      cin_eff = 1'b1;
    end
`endif
  end

  assign idx_nxt = idx_q + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_cout_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= b_eff;
            idx_q      <= '0;
            carry_q    <= cin_eff;
            // Preload slice 0 so the adder sees it during the first StRun cycle.
            add_a_q    <= in_a[SLICE_W-1:0];
            add_b_q    <= b_eff[SLICE_W-1:0];
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StRun;
          end
        end

        StRun: begin
          sum_q[idx_q] <= add_s;
          if (idx_q == LastIdx) begin
            // The final carry goes to res_cout.
            // carry_q is cleared so add_cin reads 0 outside StRun.
            res_cout_q  <= add_cout;
            carry_q     <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            idx_q       <= '0;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            carry_q <= add_cout;
            add_a_q <= a_q[idx_nxt];
            add_b_q <= b_q[idx_nxt];
            idx_q   <= idx_nxt;
          end
        end

        StDone: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = carry_q;
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_sum   = sum_q;
  assign res_cout  = res_cout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Testbench for adder_seq_ctrl.
// - A behavioural 4-bit full adder stands in for the shared adder instance.
// - Expected results come from whole-word arithmetic on the operands.

module tb_adder_seq_ctrl;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned SLICE_W = 4;
  localparam int unsigned NSLICE  = WORD_W / SLICE_W;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_a;
  logic [WORD_W-1:0]  in_b;
  logic               in_cin;
`ifdef ADDSEQ_SUB_EN
  logic               in_sub;
`endif
  logic [SLICE_W-1:0] add_a;
  logic [SLICE_W-1:0] add_b;
  logic               add_cin;
  logic [SLICE_W-1:0] add_s;
  logic               add_cout;
  logic               res_valid;
  logic               res_ready;
  logic [WORD_W-1:0]  res_sum;
  logic               res_cout;
  logic               busy;

  int n_checks;
  int n_fails;

  adder_seq_ctrl #(
    .WORD_W (WORD_W),
    .SLICE_W(SLICE_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
`ifdef ADDSEQ_SUB_EN
    .in_sub   (in_sub),
`endif
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum  (res_sum),
    .res_cout (res_cout),
    .busy     (busy)
  );

  // Shared external adder model.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Runs one operation and checks the adder drive, latency, result,
  // stability under back-pressure and the handshake back to idle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input int hold);
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic [15:0] bb;
    logic        c0;
    logic [16:0] full;
    logic [16:0] mask;
    logic [16:0] part;
    if (sub) begin
      exp_sum  = a - b;
      exp_cout = (a >= b);
      bb       = ~b;
      c0       = 1'b1;
    end else begin
      full     = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      exp_sum  = full[15:0];
      exp_cout = full[16];
      bb       = b;
      c0       = cin;
    end

    wait_ready();
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
`ifdef ADDSEQ_SUB_EN
    in_sub   = sub;
`endif
    in_valid = 1'b1;
    tick();
    // Scramble the inputs after accept; the result must not depend on them.
    in_valid = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    in_cin   = 1'($urandom);
`ifdef ADDSEQ_SUB_EN
    in_sub   = 1'($urandom);
`endif

    for (int k = 0; k < int'(NSLICE); k++) begin
      mask = (17'd1 << (SLICE_W * k)) - 17'd1;
      part = ({1'b0, a} & mask) + ({1'b0, bb} & mask) + {16'd0, c0};
      check("run_add_a", 32'(add_a), 32'(a[k*SLICE_W +: SLICE_W]));
      check("run_add_b", 32'(add_b), 32'(bb[k*SLICE_W +: SLICE_W]));
      check("run_add_cin", 32'(add_cin), 32'(part[SLICE_W*k]));
      check("run_res_valid", 32'(res_valid), 32'd0);
      check("run_in_ready", 32'(in_ready), 32'd0);
      check("run_busy", 32'(busy), 32'd1);
      tick();
    end

    // res_valid rises on the NSLICE+1-th edge, counting the accept edge.
    check("done_res_valid", 32'(res_valid), 32'd1);
    check("done_res_sum", 32'(res_sum), 32'(exp_sum));
    check("done_res_cout", 32'(res_cout), 32'(exp_cout));
    check("done_add_a", 32'(add_a), 32'd0);
    check("done_add_cin", 32'(add_cin), 32'd0);

    // Back-pressure: a new request must not be accepted while the result waits.
    in_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_res_sum", 32'(res_sum), 32'(exp_sum));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("hs_res_valid", 32'(res_valid), 32'd0);
    check("hs_in_ready", 32'(in_ready), 32'd1);
    check("hs_busy", 32'(busy), 32'd0);
    check("hs_res_sum_held", 32'(res_sum), 32'(exp_sum));
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
`ifdef ADDSEQ_SUB_EN
    in_sub    = 1'b0;
`endif
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state.
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_sum", 32'(res_sum), 32'd0);
    check("rst_res_cout", 32'(res_cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_add_cin", 32'(add_cin), 32'd0);

    // Directed cases.
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h000F, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 3);

    // Reset in the second StRun cycle discards the partial result.
    wait_ready();
    in_a     = 16'hFFFF;
    in_b     = 16'hFFFF;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_res_sum", 32'(res_sum), 32'd0);
    check("mid_rst_add_a", 32'(add_a), 32'd0);
    check("mid_rst_add_cin", 32'(add_cin), 32'd0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0);

`ifdef ADDSEQ_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
    run_op(16'h1234, 16'h1234, 1'b0, 1'b1, 0);
`endif

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
`ifdef ADDSEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, 1'($urandom), rs, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
